// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: opcodes, alu_op/mux encodings, FSM states and control bundle shared by the MIPS control path
package mips_ctrl_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_RTYPE = 3'b010;
  localparam logic [2:0] ALU_ADDI  = 3'b100;
  localparam logic [2:0] ALU_ANDI  = 3'b101;
  localparam logic [2:0] ALU_ORI   = 3'b111;
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE, S_R_EXEC,
    S_R_WB, S_BRANCH, S_JUMP, S_IMM_EXEC, S_IMM_WB, S_TRAP
  } state_t;
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_write_not;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;
  function automatic logic op_known(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW};
  endfunction
endpackage

// File: rtl/multicycle_ctrl_outdec.sv
// multicycle_ctrl_outdec: state/opcode/mem_ready to control-signal decode.
// MULTICYCLE_CTRL_ILLEGAL_TRAP_EN selects TRAP vs NOP handling of unknown opcodes.
module multicycle_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output ctrl_t      c
);
  always_comb begin
    c = '0;
    case (state)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.ir_write  = mem_ready;
        c.pc_write  = mem_ready;
      end
      S_DECODE: begin
        c.alu_src_b = SRCB_IMM_SH;
`ifndef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        c.instr_done = ~op_known(opcode);
`endif
      end
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEM_READ: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        c.mem_write  = 1'b1;
        c.i_or_d     = 1'b1;
        c.instr_done = mem_ready;
      end
      S_R_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALU_RTYPE;
      end
      S_R_WB: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = 1'b1;
        c.instr_done = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = ALU_SUB;
        c.pc_source     = PCSRC_ALUOUT;
        c.pc_write_cond = opcode == OP_BEQ;
        c.pc_write_not  = opcode == OP_BNE;
        c.instr_done    = 1'b1;
      end
      S_JUMP: begin
        c.pc_write   = 1'b1;
        c.pc_source  = PCSRC_JUMP;
        c.instr_done = 1'b1;
      end
      S_IMM_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = opcode == OP_ADDI ? ALU_ADDI : opcode == OP_ANDI ? ALU_ANDI : ALU_ORI;
      end
      S_IMM_WB: begin
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
      S_TRAP: c.illegal_op = 1'b1;
`endif
      default: ;
    endcase
  end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: MIPS multicycle main control FSM (state register + next-state logic).
// MULTICYCLE_CTRL_ILLEGAL_TRAP_EN: unknown opcodes lock into TRAP instead of acting as NOPs.
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_write_not,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal_op
);
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  localparam state_t ILL_NEXT = S_TRAP;
`else
  localparam state_t ILL_NEXT = S_FETCH;
`endif
  state_t state, next;
  ctrl_t  c;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= S_FETCH;
    else          state <= next;
  always_comb begin
    next = S_FETCH;
    case (state)
      S_FETCH:     next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:
        case (opcode)
          OP_RTYPE:                 next = S_R_EXEC;
          OP_LW, OP_SW:             next = S_MEM_ADDR;
          OP_BEQ, OP_BNE:           next = S_BRANCH;
          OP_J:                     next = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI: next = S_IMM_EXEC;
          default:                  next = ILL_NEXT;
        endcase
      S_MEM_ADDR:  next = opcode == OP_LW ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  next = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: next = mem_ready ? S_FETCH : S_MEM_WRITE;
      S_R_EXEC:    next = S_R_WB;
      S_IMM_EXEC:  next = S_IMM_WB;
      S_TRAP:      next = S_TRAP;
      default:     next = S_FETCH;
    endcase
  end
  multicycle_ctrl_outdec u_outdec (
    .state     (state),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .c         (c)
  );
  // gating by reset_n kills any in-flight write the moment reset asserts
  assign {pc_write, pc_write_cond, pc_write_not, i_or_d, mem_read, mem_write, ir_write,
          mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
          instr_done, illegal_op} = reset_n ? c : '0;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: table-driven per-cycle output checks plus a mid-write reset sequence.
module tb_multicycle_control;
  import mips_ctrl_pkg::*;
  logic clk = 1'b0, reset_n = 1'b0, mem_ready = 1'b1;
  logic [5:0] opcode = 6'b0;
  logic pc_write, pc_write_cond, pc_write_not, i_or_d, mem_read, mem_write, ir_write;
  logic mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic [19:0] act;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  multicycle_control dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_write_not(pc_write_not),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .instr_done(instr_done), .illegal_op(illegal_op)
  );
  assign act = {pc_write, pc_write_cond, pc_write_not, i_or_d, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
                instr_done, illegal_op};
  // b = {pc_write, pc_write_cond, pc_write_not, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a}
  function automatic logic [19:0] f(logic [10:0] b, logic [1:0] sb, logic [2:0] op, logic [1:0] ps, logic dn, logic il);
    return {b, sb, op, ps, dn, il};
  endfunction
  localparam logic [19:0] E_Z    = 20'b0;
  localparam logic [19:0] E_FR   = f(11'b10001010000, 2'b01, 3'b000, 2'b00, 1'b0, 1'b0);
  localparam logic [19:0] E_FW   = f(11'b00001000000, 2'b01, 3'b000, 2'b00, 1'b0, 1'b0);
  localparam logic [19:0] E_DEC  = f(11'b00000000000, 2'b11, 3'b000, 2'b00, 1'b0, 1'b0);
  localparam logic [19:0] E_NOP  = f(11'b00000000000, 2'b11, 3'b000, 2'b00, 1'b1, 1'b0);
  localparam logic [19:0] E_REX  = f(11'b00000000001, 2'b00, 3'b010, 2'b00, 1'b0, 1'b0);
  localparam logic [19:0] E_RWB  = f(11'b00000000110, 2'b00, 3'b000, 2'b00, 1'b1, 1'b0);
  localparam logic [19:0] E_MA   = f(11'b00000000001, 2'b10, 3'b000, 2'b00, 1'b0, 1'b0);
  localparam logic [19:0] E_MR   = f(11'b00011000000, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0);
  localparam logic [19:0] E_MWB  = f(11'b00000001010, 2'b00, 3'b000, 2'b00, 1'b1, 1'b0);
  localparam logic [19:0] E_MWW  = f(11'b00010100000, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0);
  localparam logic [19:0] E_MWR  = f(11'b00010100000, 2'b00, 3'b000, 2'b00, 1'b1, 1'b0);
  localparam logic [19:0] E_BNE  = f(11'b00100000001, 2'b00, 3'b001, 2'b01, 1'b1, 1'b0);
  localparam logic [19:0] E_BEQ  = f(11'b01000000001, 2'b00, 3'b001, 2'b01, 1'b1, 1'b0);
  localparam logic [19:0] E_J    = f(11'b10000000000, 2'b00, 3'b000, 2'b10, 1'b1, 1'b0);
  localparam logic [19:0] E_ADDI = f(11'b00000000001, 2'b10, 3'b100, 2'b00, 1'b0, 1'b0);
  localparam logic [19:0] E_ANDI = f(11'b00000000001, 2'b10, 3'b101, 2'b00, 1'b0, 1'b0);
  localparam logic [19:0] E_ORI  = f(11'b00000000001, 2'b10, 3'b111, 2'b00, 1'b0, 1'b0);
  localparam logic [19:0] E_IWB  = f(11'b00000000010, 2'b00, 3'b000, 2'b00, 1'b1, 1'b0);
  localparam logic [19:0] E_TRAP = f(11'b00000000000, 2'b00, 3'b000, 2'b00, 1'b0, 1'b1);
  typedef struct {
    logic        rn;
    logic [5:0]  op;
    logic        mr;
    logic [19:0] exp;
  } vec_t;
  vec_t tbl[$];
  task automatic add(input logic rn, input logic [5:0] op, input logic mr, input logic [19:0] e);
    tbl.push_back('{rn, op, mr, e});
  endtask
  task automatic check(input string name, input logic [19:0] e);
    total++;
    if (act === e) passed++;
    else $display("FAIL %s: outputs=%b required=%b", name, act, e);
  endtask
  task automatic step(input string name, input logic rn, input logic [5:0] op, input logic mr, input logic [19:0] e);
    @(negedge clk);
    reset_n = rn; opcode = op; mem_ready = mr;
    #1 check(name, e);
  endtask
  initial begin
    for (int i = 0; i < 3; i++) add(1'b0, OP_RTYPE, 1'b1, E_Z);
    add(1, OP_RTYPE, 1, E_FR); add(1, OP_RTYPE, 1, E_DEC); add(1, OP_RTYPE, 1, E_REX); add(1, OP_RTYPE, 1, E_RWB);
    add(1, OP_LW, 1, E_FR); add(1, OP_LW, 1, E_DEC); add(1, OP_LW, 1, E_MA);
    add(1, OP_LW, 0, E_MR); add(1, OP_LW, 0, E_MR); add(1, OP_LW, 1, E_MR); add(1, OP_LW, 1, E_MWB);
    add(1, OP_J, 0, E_FW); add(1, OP_J, 0, E_FW); add(1, OP_J, 0, E_FW);
    add(1, OP_J, 1, E_FR); add(1, OP_J, 1, E_DEC); add(1, OP_J, 1, E_J);
    add(1, OP_BNE, 1, E_FR); add(1, OP_BNE, 1, E_DEC); add(1, OP_BNE, 1, E_BNE);
    add(1, OP_BEQ, 1, E_FR); add(1, OP_BEQ, 1, E_DEC); add(1, OP_BEQ, 1, E_BEQ);
    add(1, OP_ORI, 1, E_FR); add(1, OP_ORI, 1, E_DEC); add(1, OP_ORI, 1, E_ORI); add(1, OP_ORI, 1, E_IWB);
    add(1, OP_ADDI, 1, E_FR); add(1, OP_ADDI, 0, E_DEC); add(1, OP_ADDI, 0, E_ADDI); add(1, OP_ADDI, 0, E_IWB);
    add(1, OP_ANDI, 1, E_FR); add(1, OP_ANDI, 1, E_DEC); add(1, OP_ANDI, 1, E_ANDI); add(1, OP_ANDI, 1, E_IWB);
    add(1, OP_SW, 1, E_FR); add(1, OP_SW, 1, E_DEC); add(1, OP_SW, 1, E_MA);
    add(1, OP_SW, 0, E_MWW); add(1, OP_SW, 1, E_MWR);
    add(1, OP_RTYPE, 1, E_FR); add(1, OP_RTYPE, 0, E_DEC); add(1, OP_RTYPE, 0, E_REX); add(1, OP_RTYPE, 0, E_RWB);
    add(1, 6'h3F, 1, E_FR);
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    add(1, 6'h3F, 1, E_DEC); add(1, 6'h3F, 1, E_TRAP); add(1, 6'h3F, 0, E_TRAP); add(1, OP_RTYPE, 1, E_TRAP);
    add(0, OP_RTYPE, 1, E_Z); add(1, OP_RTYPE, 1, E_FR);
`else
    add(1, 6'h3F, 1, E_NOP); add(1, OP_RTYPE, 1, E_FR);
`endif
    add(1, OP_RTYPE, 1, E_DEC);
    foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i].rn, tbl[i].op, tbl[i].mr, tbl[i].exp);
    step("sw_fetch", 1, OP_SW, 1, E_REX);
    step("sw_fetch2", 1, OP_SW, 1, E_RWB);
    step("sw_f", 1, OP_SW, 1, E_FR);
    step("sw_d", 1, OP_SW, 1, E_DEC);
    step("sw_ma", 1, OP_SW, 1, E_MA);
    step("sw_wait", 1, OP_SW, 0, E_MWW);
    #2 reset_n = 1'b0;
    #1 check("rst_mid_write", E_Z);
    step("rst_hold", 0, OP_SW, 1, E_Z);
    step("rst_release", 1, OP_J, 1, E_FR);
    step("restart_dec", 1, OP_J, 1, E_DEC);
    step("restart_j", 1, OP_J, 1, E_J);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
